fetch_queue: RTL and testbench

//  Decoupling instruction queue directly downstream of fetch; replaces the plain IF/ID register.

---
 rtl/fetch_queue_pkg.sv | 42 ++++
 rtl/fq_ptr_ctrl.sv | 67 ++++++
 rtl/fetch_queue.sv | 106 ++++++++++
 tb/tb_fetch_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared widths and packed-entry layout for the fetch queue; decode reuses the offsets.
// Entry word, LSB first: instruction | PC | PCPlus1 | BranchAddress | prediction | gshare index.
package fetch_queue_pkg;

    localparam int FQ_DEPTH = 4;
    localparam int FQ_AW    = 10;
    localparam int FQ_IW    = 32;
    localparam int FQ_GW    = 5;

    function automatic int fq_entry_w(input int iw, input int aw, input int gw);
        return iw + 3*aw + 1 + gw;
    endfunction

    function automatic int fq_off_pc(input int iw);
        return iw;
    endfunction

    function automatic int fq_off_pcp1(input int iw, input int aw);
        return iw + aw;
    endfunction

    function automatic int fq_off_baddr(input int iw, input int aw);
        return iw + 2*aw;
    endfunction

    function automatic int fq_off_pred(input int iw, input int aw);
        return iw + 3*aw;
    endfunction

    function automatic int fq_off_bstate(input int iw, input int aw);
        return iw + 3*aw + 1;
    endfunction

    localparam int FQ_ENTRY_W    = fq_entry_w(FQ_IW, FQ_AW, FQ_GW);
    localparam int FQ_OFF_INSTR  = 0;
    localparam int FQ_OFF_PC     = fq_off_pc(FQ_IW);
    localparam int FQ_OFF_PCP1   = fq_off_pcp1(FQ_IW, FQ_AW);
    localparam int FQ_OFF_BADDR  = fq_off_baddr(FQ_IW, FQ_AW);
    localparam int FQ_OFF_PRED   = fq_off_pred(FQ_IW, FQ_AW);
    localparam int FQ_OFF_BSTATE = fq_off_bstate(FQ_IW, FQ_AW);

endpackage

// File: rtl/fq_ptr_ctrl.sv
// Read/write pointers and occupancy for the fetch queue, with push/pop/flush gating.
// State updates one edge after the request; full is registered so fetch hold has no path from stall.
module fq_ptr_ctrl
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_fetch_vld,
    input  logic          i_stall,
    input  logic          i_flush,
    output logic          o_push,
    output logic          o_pop,
    output logic [PW-1:0] o_rd_ptr,
    output logic [PW-1:0] o_wr_ptr,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_fetch_vld & ~w_full & ~i_flush;
    assign w_pop   = ~w_empty & ~i_stall & ~i_flush;

    // Flush discards everything, including the entry presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    assign o_push   = w_push;
    assign o_pop    = w_pop;
    assign o_rd_ptr = r_rd_ptr;
    assign o_wr_ptr = r_wr_ptr;
    assign o_count  = r_count;
    assign o_full   = w_full;
    assign o_empty  = w_empty;

endmodule

// File: rtl/fetch_queue.sv
// Decoupling instruction queue between fetch and decode; first-word fall-through, one-edge latency.
// Holds fetch while full; decode stall freezes the head; EX flush empties the queue.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = FQ_AW,
    parameter int IW    = FQ_IW,
    parameter int GW    = FQ_GW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_valid,
    input  logic [IW-1:0] instruction,
    input  logic [AW-1:0] PC,
    input  logic [AW-1:0] PCPlus1,
    input  logic          prediction,
    input  logic [AW-1:0] Branch_state_F,
    input  logic [AW-1:0] BranchAddress_F,
    input  logic          flush,
    input  logic          stall_D,
    output logic          hold_F,
    output logic          valid_D,
    output logic [IW-1:0] instruction_D,
    output logic [AW-1:0] PC_D,
    output logic [AW-1:0] PCPlus1_D,
    output logic [AW-1:0] BranchAddress_D,
    output logic [AW-1:0] Branch_state_D,
    output logic          prediction_D,
    output logic [CW-1:0] count
);

    localparam int EW         = fq_entry_w(IW, AW, GW);
    localparam int OFF_PC     = fq_off_pc(IW);
    localparam int OFF_PCP1   = fq_off_pcp1(IW, AW);
    localparam int OFF_BADDR  = fq_off_baddr(IW, AW);
    localparam int OFF_PRED   = fq_off_pred(IW, AW);
    localparam int OFF_BSTATE = fq_off_bstate(IW, AW);

    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_rd_ptr;
    logic [PW-1:0] w_wr_ptr;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;
    logic          w_unused_bstate_hi;

    logic [EW-1:0] r_mem [DEPTH];

    fq_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk         (clk),
        .i_rst_n     (rst),
        .i_fetch_vld (fetch_valid),
        .i_stall     (stall_D),
        .i_flush     (flush),
        .o_push      (w_push),
        .o_pop       (w_pop),
        .o_rd_ptr    (w_rd_ptr),
        .o_wr_ptr    (w_wr_ptr),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Only the low GW bits of the gshare index are architecturally meaningful.
    assign w_entry = {Branch_state_F[GW-1:0], prediction, BranchAddress_F, PCPlus1, PC, instruction};
    assign w_unused_bstate_hi = ^{Branch_state_F[AW-1:GW], w_pop};

    // Storage is deliberately unreset; outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[w_wr_ptr] <= w_entry;
    end

    assign w_head = r_mem[w_rd_ptr];

    always_comb begin
        valid_D         = 1'b0;
        instruction_D   = '0;
        PC_D            = '0;
        PCPlus1_D       = '0;
        BranchAddress_D = '0;
        Branch_state_D  = '0;
        prediction_D    = 1'b0;
        if (!w_empty) begin
            valid_D         = 1'b1;
            instruction_D   = w_head[0 +: IW];
            PC_D            = w_head[OFF_PC +: AW];
            PCPlus1_D       = w_head[OFF_PCP1 +: AW];
            BranchAddress_D = w_head[OFF_BADDR +: AW];
            Branch_state_D  = {{(AW-GW){1'b0}}, w_head[OFF_BSTATE +: GW]};
            prediction_D    = w_head[OFF_PRED];
        end
    end

    assign hold_F = w_full;
    assign count  = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed + randomized bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] instruction;
    logic [9:0]  PC;
    logic [9:0]  PCPlus1;
    logic        prediction;
    logic [9:0]  Branch_state_F;
    logic [9:0]  BranchAddress_F;
    logic        flush;
    logic        stall_D;
    logic        hold_F;
    logic        valid_D;
    logic [31:0] instruction_D;
    logic [9:0]  PC_D;
    logic [9:0]  PCPlus1_D;
    logic [9:0]  BranchAddress_D;
    logic [9:0]  Branch_state_D;
    logic        prediction_D;
    logic [2:0]  count;

    fetch_queue dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_valid     (fetch_valid),
        .instruction     (instruction),
        .PC              (PC),
        .PCPlus1         (PCPlus1),
        .prediction      (prediction),
        .Branch_state_F  (Branch_state_F),
        .BranchAddress_F (BranchAddress_F),
        .flush           (flush),
        .stall_D         (stall_D),
        .hold_F          (hold_F),
        .valid_D         (valid_D),
        .instruction_D   (instruction_D),
        .PC_D            (PC_D),
        .PCPlus1_D       (PCPlus1_D),
        .BranchAddress_D (BranchAddress_D),
        .Branch_state_D  (Branch_state_D),
        .prediction_D    (prediction_D),
        .count           (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ins;
        logic [9:0]  pc;
        logic [9:0]  pc1;
        logic [9:0]  ba;
        logic [9:0]  bs;
        logic        pr;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   last_push;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [9:0] pc, input logic [31:0] ins);
        PC          = pc;
        PCPlus1     = pc + 10'd1;
        instruction = ins;
    endtask

    // Compare DUT head/occupancy with the model, clock one edge, then apply the queue rules.
    task automatic step();
        ent_t exp_h;
        bit   m_full, m_push, m_pop;
        exp_h = '0;
        if (q.size() != 0) exp_h = q[0];
        chk("count",         32'(count),           32'(q.size()));
        chk("valid_D",       32'(valid_D),         32'(q.size() != 0));
        chk("hold_F",        32'(hold_F),          32'(q.size() == 4));
        chk("instruction_D", instruction_D,        exp_h.ins);
        chk("PC_D",          32'(PC_D),            32'(exp_h.pc));
        chk("PCPlus1_D",     32'(PCPlus1_D),       32'(exp_h.pc1));
        chk("BranchAddr_D",  32'(BranchAddress_D), 32'(exp_h.ba));
        chk("Branch_state_D",32'(Branch_state_D),  32'(exp_h.bs));
        chk("prediction_D",  32'(prediction_D),    32'(exp_h.pr));
        m_full = (q.size() == 4);
        m_push = rst && fetch_valid && !m_full && !flush;
        m_pop  = rst && (q.size() != 0) && !stall_D && !flush;
        @(posedge clk);
        if (!rst || flush) begin
            q.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back('{ins: instruction, pc: PC, pc1: PCPlus1,
                                     ba: BranchAddress_F, bs: Branch_state_F & 10'h01F,
                                     pr: prediction});
        end
        last_push = m_push;
        @(negedge clk);
    endtask

    initial begin
        int idx;
        int guard;
        rst = 1'b0; fetch_valid = 1'b1; flush = 1'b0; stall_D = 1'b0;
        prediction = 1'b0; Branch_state_F = '0; BranchAddress_F = '0;
        present(10'h000, 32'h1000_0000);
        @(posedge clk);
        @(negedge clk);

        // Reset held with fetch presenting
        repeat (2) step();

        // Fill under stall, fifth push dropped, then drain in order
        rst = 1'b1; stall_D = 1'b1;
        for (int p = 0; p < 5; p++) begin
            present(10'(p), 32'h1000_0000 + 32'(p));
            step();
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_hold",  32'(hold_F), 32'd1);
        stall_D = 1'b0; fetch_valid = 1'b0;
        repeat (5) step();

        // Full with pop and fetch presenting: push blocked first cycle only
        stall_D = 1'b1; fetch_valid = 1'b1;
        for (int p = 0; p < 4; p++) begin
            present(10'h020 + 10'(p), 32'h1000_0020 + 32'(p));
            step();
        end
        stall_D = 1'b0;
        present(10'h030, 32'h1000_0030);
        step();
        chk("full_pop_push_dropped", 32'(last_push), 32'd0);
        step();
        chk("next_push_accepted", 32'(last_push), 32'd1);
        fetch_valid = 1'b0;
        repeat (6) step();

        // Wrap: 10 entries with stall toggling, fetch re-presents until accepted
        idx = 0; guard = 0; fetch_valid = 1'b1;
        while (idx < 10 && guard < 60) begin
            present(10'h3F8 + 10'(idx), 32'h1000_0000 + 32'(10'h3F8 + 10'(idx)));
            stall_D = guard[0];
            step();
            if (last_push) idx++;
            guard++;
        end
        chk("wrap_all_pushed", 32'(idx), 32'd10);
        fetch_valid = 1'b0; stall_D = 1'b0;
        repeat (6) step();

        // Flush with an incoming entry
        fetch_valid = 1'b1;
        for (int p = 0; p < 3; p++) begin
            present(10'h050 + 10'(p), 32'h1000_0050 + 32'(p));
            step();
        end
        flush = 1'b1;
        present(10'h055, 32'h1000_0055);
        step();
        flush = 1'b0;
        chk("flush_valid", 32'(valid_D), 32'd0);
        chk("flush_count", 32'(count), 32'd0);
        present(10'h060, 32'h1000_0060);
        step();
        fetch_valid = 1'b0;
        chk("post_flush_head", 32'(PC_D), 32'h060);
        step();

        // Metadata fields
        stall_D = 1'b1; fetch_valid = 1'b1;
        present(10'h070, 32'hCAFE_0070);
        prediction = 1'b1; Branch_state_F = 10'h01F; BranchAddress_F = 10'h2A0;
        step();
        chk("meta_pred",  32'(prediction_D),    32'd1);
        chk("meta_bs",    32'(Branch_state_D),  32'h01F);
        chk("meta_baddr", 32'(BranchAddress_D), 32'h2A0);
        fetch_valid = 1'b0; stall_D = 1'b0;
        step();
        fetch_valid = 1'b1;
        present(10'h071, 32'hCAFE_0071);
        prediction = 1'b0; Branch_state_F = 10'h3E5; BranchAddress_F = 10'h111;
        step();
        fetch_valid = 1'b0;
        chk("meta_bs_trunc", 32'(Branch_state_D), 32'h005);
        step();

        // Randomized traffic with sparse flushes and one mid-run reset
        for (int c = 0; c < 400; c++) begin
            fetch_valid     = ($urandom_range(0, 3) != 0);
            stall_D         = ($urandom_range(0, 2) == 0);
            flush           = ($urandom_range(0, 24) == 0);
            rst             = !(c == 200);
            prediction      = 1'($urandom);
            Branch_state_F  = 10'($urandom);
            BranchAddress_F = 10'($urandom);
            present(10'($urandom), $urandom);
            step();
        end
        rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; stall_D = 1'b0;
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
